// File: rtl/pong_pkg.sv
// Shared encodings for the pong design: game states, countdown codes, system clock rate.
package pong_pkg;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    PLAY  = 3'd1,
    HOLD  = 3'd2,
    SCORE = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam logic [1:0] CD_IDLE = 2'd0;
  localparam logic [1:0] CD_1    = 2'd1;
  localparam logic [1:0] CD_2    = 2'd2;
  localparam logic [1:0] CD_3    = 2'd3;

  localparam int unsigned CLK_HZ = 100_000_000;

endpackage

// File: rtl/pong_game_ctrl_rise_edge.sv
// Rising-edge detector for a debounced button level; the previous level is registered.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_prev;

  always_ff @(posedge clk) begin
    if (reset) level_prev <= 1'b0;
    else       level_prev <= level;
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: countdown, play, user pause, post-point hold and game over.
// Owns both scores and gates ball/paddle motion through run.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned HOLD_CYCLES = CLK_HZ / 2,
  parameter int unsigned TMR_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause_btn,
  input  logic               point_l,
  input  logic               point_r,
  input  logic [1:0]         countdown,
  output logic               pause_tick,
  output logic               run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [TMR_W-1:0]   HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  game_state_t        state, state_nxt;
  logic               btn_edge;
  logic               wait_start, wait_start_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic [SCORE_W-1:0] score_l_nxt, score_r_nxt;
  logic               pause_tick_nxt, run_nxt, ball_reset_nxt, serve_dir_nxt;
  logic               game_over_nxt, winner_nxt;

  rise_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .level (pause_btn),
    .rise  (btn_edge)
  );

  assign score_l_inc = score_l + SCORE_W'(1);
  assign score_r_inc = score_r + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COUNT;
      wait_start <= 1'b1;
      timer      <= '0;
      score_l    <= '0;
      score_r    <= '0;
      pause_tick <= 1'b0;
      run        <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_start <= wait_start_nxt;
      timer      <= timer_nxt;
      score_l    <= score_l_nxt;
      score_r    <= score_r_nxt;
      pause_tick <= pause_tick_nxt;
      run        <= run_nxt;
      ball_reset <= ball_reset_nxt;
      serve_dir  <= serve_dir_nxt;
      game_over  <= game_over_nxt;
      winner     <= winner_nxt;
    end
  end

  // Point events outrank the pause button; lower-priority events in the same cycle are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      COUNT: if (!wait_start && countdown == CD_IDLE) state_nxt = PLAY;
      PLAY: begin
        if (point_l)       state_nxt = (score_l_inc == WIN_VAL) ? OVER : SCORE;
        else if (point_r)  state_nxt = (score_r_inc == WIN_VAL) ? OVER : SCORE;
        else if (btn_edge) state_nxt = HOLD;
      end
      HOLD:    if (btn_edge) state_nxt = COUNT;
      SCORE:   if (timer == HOLD_LAST) state_nxt = COUNT;
      OVER:    if (btn_edge) state_nxt = COUNT;
      default: state_nxt = COUNT;
    endcase
  end

  always_comb begin
    pause_tick_nxt = 1'b0;
    ball_reset_nxt = 1'b0;
    serve_dir_nxt  = serve_dir;
    score_l_nxt    = score_l;
    score_r_nxt    = score_r;
    game_over_nxt  = game_over;
    winner_nxt     = winner;
    timer_nxt      = timer;
    run_nxt        = (state_nxt == PLAY);
    case (state)
      PLAY: begin
        if (point_l) begin
          score_l_nxt = score_l_inc;
          if (score_l_inc == WIN_VAL) begin
            game_over_nxt = 1'b1;
            winner_nxt    = 1'b0;
          end else begin
            timer_nxt      = '0;
            ball_reset_nxt = 1'b1;
            serve_dir_nxt  = 1'b0;
          end
        end else if (point_r) begin
          score_r_nxt = score_r_inc;
          if (score_r_inc == WIN_VAL) begin
            game_over_nxt = 1'b1;
            winner_nxt    = 1'b1;
          end else begin
            timer_nxt      = '0;
            ball_reset_nxt = 1'b1;
            serve_dir_nxt  = 1'b1;
          end
        end
      end
      HOLD: if (btn_edge) pause_tick_nxt = 1'b1;
      SCORE: begin
        if (timer == HOLD_LAST) begin
          pause_tick_nxt = 1'b1;
          timer_nxt      = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      OVER: begin
        if (btn_edge) begin
          score_l_nxt    = '0;
          score_r_nxt    = '0;
          game_over_nxt  = 1'b0;
          ball_reset_nxt = 1'b1;
          pause_tick_nxt = 1'b1;
          serve_dir_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // A new countdown leaves the block at 0 for one cycle before it loads 3; wait until it is seen running.
  always_comb begin
    wait_start_nxt = wait_start;
    if (pause_tick_nxt)              wait_start_nxt = 1'b1;
    else if (countdown != CD_IDLE)   wait_start_nxt = 1'b0;
  end

endmodule
